// File: rtl/rom_sample_streamer.sv
// ROM-to-stream feeder for the rank-order filter: reads NUM_SAMPLES words from a synchronous ROM,
// streams them over valid/ready, appends FLUSH_LEN pad beats, and drives the result-RAM write
// port delayed by WR_DELAY accepted beats.
module rom_sample_streamer #(
  parameter int unsigned          DATA_BITS   = 8,
  parameter int unsigned          ADDR_BITS   = 8,
  parameter int unsigned          NUM_SAMPLES = 255,
  parameter int unsigned          FLUSH_LEN   = 100,
  parameter logic [DATA_BITS-1:0] PAD_VALUE   = '0,
  parameter int unsigned          WR_DELAY    = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_ce,
  input  logic [DATA_BITS-1:0] rom_q,
  output logic [DATA_BITS-1:0] s_data,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW  = $clog2(NUM_SAMPLES + FLUSH_LEN + 1);
  // One extra address bit so rom_addr can park at NUM_SAMPLES == 2**ADDR_BITS.
  localparam int unsigned AW1 = ADDR_BITS + 1;

  localparam logic [AW1-1:0] NumAddr    = AW1'(NUM_SAMPLES);
  localparam logic [CW-1:0]  LastSample = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0]  LastBeat   = CW'(NUM_SAMPLES + FLUSH_LEN - 1);
  localparam logic [CW-1:0]  AccMax     = {CW{1'b1}};

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StFlush, StDone} state_e;

  state_e state_q, state_d;

  logic [AW1-1:0]       rom_addr_q, rom_addr_d;
  logic [CW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic                 accept;
  logic                 wr_gate;

  assign accept   = s_valid & s_ready;
  assign rom_addr = rom_addr_q[ADDR_BITS-1:0];
  assign wr_addr  = wr_addr_q;

  // Write strobe opens once WR_DELAY beats have been accepted.
  if (WR_DELAY == 0) begin : g_no_delay
    assign wr_gate = 1'b1;
  end else begin : g_delay
    assign wr_gate = (acc_cnt_q >= CW'(WR_DELAY));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StStream;
      StStream: begin
        if (accept && acc_cnt_q == LastSample) begin
          state_d = (FLUSH_LEN == 0) ? StDone : StFlush;
        end
      end
      StFlush:  if (accept && acc_cnt_q == LastBeat) state_d = StDone;
      StDone:   if (start) state_d = StLoad;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; rom_ce follows s_ready only while streaming samples.
  always_comb begin
    s_valid = 1'b0;
    s_data  = '0;
    rom_ce  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StLoad: begin
        rom_ce = 1'b1;
        busy   = 1'b1;
      end
      StStream: begin
        s_valid = 1'b1;
        s_data  = rom_q;
        rom_ce  = s_ready;
        busy    = 1'b1;
      end
      StFlush: begin
        s_valid = 1'b1;
        s_data  = PAD_VALUE;
        busy    = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
    wr_en = s_valid & s_ready & wr_gate;
  end

  // Address and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_q <= '0;
      acc_cnt_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // Counter next-state: clear on start, prefetch address 1 in LOAD, advance on accepted beats.
  always_comb begin
    rom_addr_d = rom_addr_q;
    acc_cnt_d  = acc_cnt_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rom_addr_d = '0;
          acc_cnt_d  = '0;
          wr_addr_d  = '0;
        end
      end
      StLoad:   rom_addr_d = AW1'(1);
      StStream: begin
        // Parks at NUM_SAMPLES; the trailing ROM read there is never presented.
        if (accept && rom_addr_q < NumAddr) rom_addr_d = rom_addr_q + AW1'(1);
      end
      default: ;
    endcase
    if (accept && acc_cnt_q != AccMax) acc_cnt_d = acc_cnt_q + CW'(1);
    if (wr_en) wr_addr_d = wr_addr_q + ADDR_BITS'(1);
  end

endmodule

// File: tb/tb_rom_sample_streamer.sv
// Bench for rom_sample_streamer: three instances (small, single-sample, default config), each
// backed by a synchronous ROM model; expected beats are queued at run start and popped on accept.
module tb_rom_sample_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0]      start_v, s_ready_v, rom_ce_v, s_valid_v, wr_en_v, busy_v, done_v;
  logic [2:0][7:0] rom_addr_v, rom_q_v, s_data_v, wr_addr_v;
  logic [7:0]      rom_mem [3][256];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       we;
    logic [7:0] wa;
  } beat_t;

  beat_t sb[$];

  // Synchronous ROMs: capture address and update output when rom_ce is high.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rom_ce_v[k]) rom_q_v[k] <= rom_mem[k][rom_addr_v[k]];
    end
  end

  rom_sample_streamer #(.NUM_SAMPLES(4), .FLUSH_LEN(2), .WR_DELAY(2)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .rom_addr(rom_addr_v[0]), .rom_ce(rom_ce_v[0]),
    .rom_q(rom_q_v[0]), .s_data(s_data_v[0]), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
    .wr_addr(wr_addr_v[0]), .wr_en(wr_en_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  rom_sample_streamer #(.NUM_SAMPLES(1), .FLUSH_LEN(0), .WR_DELAY(0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .rom_addr(rom_addr_v[1]), .rom_ce(rom_ce_v[1]),
    .rom_q(rom_q_v[1]), .s_data(s_data_v[1]), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
    .wr_addr(wr_addr_v[1]), .wr_en(wr_en_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  rom_sample_streamer u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .rom_addr(rom_addr_v[2]), .rom_ce(rom_ce_v[2]),
    .rom_q(rom_q_v[2]), .s_data(s_data_v[2]), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
    .wr_addr(wr_addr_v[2]), .wr_en(wr_en_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs of instance k at their reset values.
  task automatic chk_quiet(input string tag, input int k);
    chk(tag, {s_valid_v[k], busy_v[k], done_v[k], wr_en_v[k], rom_ce_v[k], s_data_v[k],
              rom_addr_v[k], wr_addr_v[k]}, 32'h0);
  endtask

  task automatic push_run(input int k, input int ns, input int fl, input int wd);
    beat_t b;
    for (int i = 0; i < ns + fl; i++) begin
      b.data = (i < ns) ? rom_mem[k][i] : 8'h00;
      b.we   = (i >= wd);
      b.wa   = 8'(i - wd);
      sb.push_back(b);
    end
  endtask

  // Called at a negedge; returns at the negedge two cycles later (first STREAM cycle).
  task automatic start_run(input int k);
    start_v[k]   = 1'b1;
    s_ready_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    #1;
    chk("load_busy", busy_v[k], 1);
    chk("load_valid", s_valid_v[k], 0);
    chk("load_rom_ce", rom_ce_v[k], 1);
    chk("load_rom_addr", rom_addr_v[k], 0);
    @(negedge clk);
  endtask

  // Drains the scoreboard against instance k; optional stall window and reset abort.
  task automatic run_beats(input int k, input int ns, input int stall_beat, input int stall_len,
                           input int abort_beat);
    beat_t exp;
    int beat = 0;
    int stalls = 0;
    int cyc = 0;
    while (sb.size() > 0 && cyc < 1000) begin
      if (beat == abort_beat) begin
        rst = 1'b0;
        #1;
        chk_quiet("abort_outputs", k);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      s_ready_v[k] = !(beat == stall_beat && stalls < stall_len);
      #1;
      exp = sb[0];
      chk("s_valid", s_valid_v[k], 1);
      chk("s_data", s_data_v[k], exp.data);
      if (s_ready_v[k]) begin
        void'(sb.pop_front());
        chk("wr_en", wr_en_v[k], exp.we);
        if (exp.we) chk("wr_addr", wr_addr_v[k], exp.wa);
        chk("rom_ce", rom_ce_v[k], beat < ns);
        beat++;
      end else begin
        chk("stall_rom_addr", rom_addr_v[k], beat + 1);
        chk("stall_rom_ce", rom_ce_v[k], 0);
        chk("stall_wr_en", wr_en_v[k], 0);
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    if (sb.size() > 0) begin
      chk("beat_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic finish_run(input int k, input int exp_wr_addr);
    #1;
    chk("end_done", done_v[k], 1);
    chk("end_busy", busy_v[k], 0);
    chk("end_valid", s_valid_v[k], 0);
    chk("end_wr_en", wr_en_v[k], 0);
    chk("end_wr_addr", wr_addr_v[k], exp_wr_addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_mem[0][i] = 8'(i);
      rom_mem[1][i] = 8'(i * 3 + 5);
      rom_mem[2][i] = 8'(i * 7 + 3);
    end
    rom_mem[0][0] = 8'd10;
    rom_mem[0][1] = 8'd20;
    rom_mem[0][2] = 8'd30;
    rom_mem[0][3] = 8'd40;

    // Reset with random inputs, then idle without start.
    rst       = 1'b0;
    start_v   = '0;
    s_ready_v = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start_v   = 3'($urandom);
      s_ready_v = 3'($urandom);
      #1;
      for (int k = 0; k < 3; k++) chk_quiet("reset_outputs", k);
    end
    @(negedge clk);
    start_v = '0;
    rst     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_ready_v = 3'($urandom);
      #1;
      for (int k = 0; k < 3; k++) chk_quiet("idle_no_start", k);
    end
    @(negedge clk);

    // Nominal run.
    push_run(0, 4, 2, 2);
    start_run(0);
    run_beats(0, 4, -1, 0, -1);
    finish_run(0, 4);

    // Backpressure on sample 20 for three cycles.
    @(negedge clk);
    push_run(0, 4, 2, 2);
    start_run(0);
    run_beats(0, 4, 1, 3, -1);
    finish_run(0, 4);

    // Abort on the first flush beat, then replay from the top.
    @(negedge clk);
    push_run(0, 4, 2, 2);
    start_run(0);
    run_beats(0, 4, -1, 0, 4);
    #1;
    chk_quiet("after_abort", 0);
    @(negedge clk);
    push_run(0, 4, 2, 2);
    start_run(0);
    run_beats(0, 4, -1, 0, -1);
    finish_run(0, 4);

    // Single sample, no flush, no delay; start held while busy is ignored.
    @(negedge clk);
    push_run(1, 1, 0, 0);
    start_run(1);
    start_v[1] = 1'b1;
    run_beats(1, 1, 0, 1, -1);
    start_v[1] = 1'b0;
    finish_run(1, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("done_hold", done_v[1], 1);
      chk("done_hold_busy", busy_v[1], 0);
    end

    // Default config twice, restarting from DONE.
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      push_run(2, 255, 100, 100);
      start_run(2);
      run_beats(2, 255, -1, 0, -1);
      finish_run(2, 255);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
